channel_sequencer: RTL
======================

Name: channel_sequencer

Overview:
- Channel-side responder to the central launch controller. Loads one waveform (a list of value/duration entries) from the host stream and raises o_armed when the complete waveform is buffered.
- Consumes the one-cycle start pulse and plays the entries out as a held output level. Pulses o_done when playback completes, then drops armed.
- One instance per DC/RF/LI channel. o_armed feeds the launcher's armed vector; i_start is that channel's start bit.

Parameters:
- DEPTH, 64, maximum entries per waveform (power of two, ≥2).
- VAL_W, 16, width of the output sample value.
- DUR_W, 16, width of the per-entry duration field.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_wr_valid  in  1  host entry valid
- i_wr_data  in  VAL_W+DUR_W  entry: {value[VAL_W+DUR_W-1:DUR_W], duration[DUR_W-1:0]}
- i_wr_last  in  1  marks final entry of the waveform
- o_wr_ready  out  1  entry accepted when i_wr_valid && o_wr_ready
- i_start  in  1  one-cycle start pulse from the launcher
- i_abort  in  1  flush buffer, return to LOAD
- o_armed  out  1  complete waveform buffered, awaiting start
- o_value  out  VAL_W  current output level (registered)
- o_busy  out  1  playback in progress
- o_done  out  1  one-cycle pulse at end of playback
- o_error  out  1  sticky: overflow or start while not armed; cleared by i_rst or i_abort

Behaviour:
- Reset: FSM=LOAD, FIFO empty, o_wr_ready=1, o_armed=0, o_value=0, o_busy=0, o_done=0, o_error=0.
- States: LOAD, ARMED, PLAY.
- LOAD:
  - o_wr_ready = !full. Each handshake pushes one entry.
  - A handshake with i_wr_last=1 moves to ARMED next cycle. o_armed is registered and rises the cycle after the last handshake.
  - FIFO reaching full without last: set o_error, hold o_wr_ready=0, stay in LOAD until i_abort.
- ARMED:
  - o_wr_ready=0, o_armed=1.
  - i_start=1 moves to PLAY. On that same edge, o_value loads the head entry's value, its duration is loaded into the down-counter, the head is popped, and o_armed→0, o_busy→1. First sample is visible the cycle after i_start.
- PLAY:
  - Each entry is held for duration+1 cycles; duration=0 gives one cycle.
  - When the counter hits 0 and the FIFO is non-empty, load the next entry on the next edge. There are no gap cycles between entries.
  - When the counter hits 0 and the FIFO is empty, go to LOAD next edge with o_done=1 for exactly one cycle, o_busy=0, o_wr_ready=1.
  - o_value holds the final entry's value after playback; it is never returned to 0 except by reset.
- i_start outside ARMED: ignored, sets o_error. A start in the same cycle as the last write handshake is also an error, because o_armed is not yet high.
- i_abort (any state, priority below i_rst, above all else): flush FIFO, counter=0, state=LOAD, o_armed=0, o_busy=0, o_error=0, no o_done. o_value is held.
- Single-entry waveform: valid; plays one entry then done.
- Counter is DUR_W bits, decrement only. The full duration range 0..2^DUR_W-1 is legal.

Decomposition:
- Package seq_pkg: localparam widths, packed struct seq_entry_t {value, duration}, enum seq_state_t {LOAD, ARMED, PLAY}.
- Sub-module sync_fifo (DEPTH, WIDTH=VAL_W+DUR_W):
  - push/pop/flush, full/empty, first-word-fall-through head output.
  - Pointers carry one extra wrap bit for the full/empty distinction.
- The sequencer holds the FSM, duration counter, and output registers.

Test Plan:
- Basic play: load {0x1111,2},{0x2222,0},{0x3333,1 last}; armed rises 1 cycle after last; start → o_value 0x1111×3, 0x2222×1, 0x3333×2; o_done pulses the next cycle; o_value stays 0x3333.
- Back-pressure/overflow: DEPTH=4, push 4 entries without last → o_wr_ready=0, o_error=1, armed never rises; i_abort → o_error=0, o_wr_ready=1.
- Spurious start: i_start in LOAD, and i_start in the cycle of the last handshake → no playback, o_error=1, later valid start still plays.
- Abort mid-play: abort during the 2nd entry → o_busy=0 next cycle, no o_done, o_value held; a new 1-entry waveform reloads and plays.
- Reset mid-play: i_rst asserted during PLAY → next cycle all outputs at reset values, FIFO empty.
- Max duration & wrap: entry duration=0xFFFF → held 65536 cycles; load DEPTH entries with last on final → all play, pointer wrap correct over two consecutive waveforms.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types for the channel sequencer: default widths, the waveform entry
// layout and the sequencer FSM states.
package seq_pkg;

  localparam int SEQ_DEPTH = 64;
  localparam int SEQ_VAL_W = 16;
  localparam int SEQ_DUR_W = 16;

  // Host entry layout: value in the upper bits, hold duration in the lower bits.
  typedef struct packed {
    logic [SEQ_VAL_W-1:0] value;
    logic [SEQ_DUR_W-1:0] duration;
  } seq_entry_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ARMED = 2'd1,
    PLAY  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Pointers carry one extra wrap bit
// so that full and empty can be told apart when the index bits match.
module sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pushes into a full FIFO and pops from an empty one are dropped.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/channel_sequencer.sv
// Per-channel waveform player: buffers a host-loaded list of value/duration
// entries, arms, and on the launcher's start pulse plays them as a held level.
module channel_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH = SEQ_DEPTH,
  parameter int VAL_W = SEQ_VAL_W,
  parameter int DUR_W = SEQ_DUR_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_valid,
  input  logic [VAL_W+DUR_W-1:0] i_wr_data,
  input  logic                   i_wr_last,
  output logic                   o_wr_ready,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic                   o_armed,
  output logic [VAL_W-1:0]       o_value,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error
);

  localparam int W = VAL_W + DUR_W;

  // Write channel: an entry transfers on any edge where i_wr_valid && o_wr_ready.
  // o_wr_ready depends only on registered state, never on i_wr_valid.

  seq_state_t       state_q, state_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             armed_q, armed_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [W-1:0]     fifo_head;
  logic             wr_ready;
  logic             wr_fire;
  logic [VAL_W-1:0] head_value;
  logic [DUR_W-1:0] head_dur;

  assign wr_ready   = (state_q == LOAD) && !fifo_full;
  assign wr_fire    = i_wr_valid && wr_ready;
  assign head_value = fifo_head[W-1:DUR_W];
  assign head_dur   = fifo_head[DUR_W-1:0];

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push_i  (wr_fire),
    .pop_i   (fifo_pop),
    .flush_i (i_abort),
    .data_i  (i_wr_data),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    armed_d  = armed_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    fifo_pop = 1'b0;
    if (i_abort) begin
      state_d = LOAD;
      cnt_d   = '0;
      armed_d = 1'b0;
      busy_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      if (i_start && (state_q != ARMED)) error_d = 1'b1;
      case (state_q)
        LOAD: begin
          // A full buffer with no last entry can never arm; flag it and wait for abort.
          if (fifo_full) error_d = 1'b1;
          if (wr_fire && i_wr_last) begin
            state_d = ARMED;
            armed_d = 1'b1;
          end
        end
        ARMED: begin
          if (i_start) begin
            state_d  = PLAY;
            value_d  = head_value;
            cnt_d    = head_dur;
            fifo_pop = 1'b1;
            armed_d  = 1'b0;
            busy_d   = 1'b1;
          end
        end
        PLAY: begin
          if (cnt_q == '0) begin
            if (!fifo_empty) begin
              value_d  = head_value;
              cnt_d    = head_dur;
              fifo_pop = 1'b1;
            end else begin
              state_d = LOAD;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      value_q <= '0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      armed_q <= armed_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign o_wr_ready = wr_ready;
  assign o_armed    = armed_q;
  assign o_value    = value_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;

endmodule
